// File: rtl/i2s_tx_serializer.sv
// Stereo I2S/left-justified DAC serializer with a one-pair holding buffer; MSB on dacdat 1 bclk after the slot edge (LJ) or 2 (I2S).
// Backpressure: data_ready drops while a pair is held and rises again once the pair is committed at a left start.
module i2s_tx_serializer #(
    parameter int WIDTH      = 16,
    parameter bit I2S_MODE   = 1'b1,
    parameter bit LEFT_LEVEL = 1'b0
) (
    input  logic             bclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             daclrc,
    input  logic [WIDTH-1:0] left_data,
    input  logic [WIDTH-1:0] right_data,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dacdat,
    output logic             frame_start,
    output logic             underrun
);

    localparam int BPW = $clog2(WIDTH + 2);
    localparam logic [BPW-1:0] POS_MAX = BPW'(WIDTH + 1);

    logic             lrc_q;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] hold_l_q, hold_l_d;
    logic [WIDTH-1:0] hold_r_q, hold_r_d;
    logic [WIDTH-1:0] shift_l_q, shift_l_d;
    logic [WIDTH-1:0] shift_r_q, shift_r_d;
    logic [BPW-1:0]   bitpos_q, bitpos_d;
    logic             armed_q, armed_d;
    logic             dacdat_q, dacdat_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;

    logic             slot_edge;
    logic             in_left;
    logic             left_start;
    logic             xfer;
    logic [BPW-1:0]   pos;
    logic [BPW-1:0]   shamt;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] shifted;
    logic             play;

    always_comb begin
        slot_edge  = daclrc != lrc_q;
        in_left    = daclrc == LEFT_LEVEL;
        left_start = slot_edge & in_left;
        data_ready = enable & ~hold_full_q & ~reset;
        xfer       = data_valid & data_ready;

        hold_full_d   = hold_full_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        armed_d       = armed_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (!enable) begin
            hold_full_d = 1'b0;
            armed_d     = 1'b0;
        end else begin
            if (xfer) begin
                hold_l_d    = left_data;
                hold_r_d    = right_data;
                hold_full_d = 1'b1;
            end
            // A held pair blocks data_ready, so xfer and a held commit are exclusive.
            if (left_start) begin
                armed_d = 1'b1;
                if (hold_full_q) begin
                    shift_l_d     = hold_l_q;
                    shift_r_d     = hold_r_q;
                    hold_full_d   = 1'b0;
                    frame_start_d = 1'b1;
                end else if (xfer) begin
                    shift_l_d     = left_data;
                    shift_r_d     = right_data;
                    hold_full_d   = 1'b0;
                    frame_start_d = 1'b1;
                end else begin
                    shift_l_d  = '0;
                    shift_r_d  = '0;
                    underrun_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pos      = slot_edge ? '0 : bitpos_q;
        bitpos_d = (pos >= POS_MAX) ? POS_MAX : pos + 1'b1;
        active   = in_left ? shift_l_d : shift_r_d;
        // Shifting by >= WIDTH empties the word, which gives the zero padding past the LSB.
        shamt    = I2S_MODE ? pos - 1'b1 : pos;
        shifted  = active << shamt;
        play     = enable & (armed_q | left_start);
        dacdat_d = 1'b0;
        if (play && !(I2S_MODE && pos == '0)) begin
            dacdat_d = shifted[WIDTH-1];
        end
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            lrc_q         <= daclrc;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            shift_l_q     <= '0;
            shift_r_q     <= '0;
            bitpos_q      <= POS_MAX;
            armed_q       <= 1'b0;
            dacdat_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            lrc_q         <= daclrc;
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
            bitpos_q      <= bitpos_d;
            armed_q       <= armed_d;
            dacdat_q      <= dacdat_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign dacdat      = dacdat_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule
